// File: rtl/router_pkt_tx_if.sv
// Request, payload and router-side signals of the packet transmitter.
interface router_pkt_tx_if;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned DATA_W = 8;

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              req_ready;
  logic [DATA_W-1:0] pl_data;
  logic              pl_valid;
  logic              pl_ready;
  logic              busy;
  logic              err;
  logic              pkt_valid;
  logic [DATA_W-1:0] tx_data;
  logic              done;
  logic              pkt_err;
  logic              bad_req;

  // Requester/router side: offers requests and payload, models the router.
  modport master (
    output req_valid, req_addr, req_len, pl_data, pl_valid, busy, err,
    input  req_ready, pl_ready, pkt_valid, tx_data, done, pkt_err, bad_req
  );

  // Transmitter side.
  modport slave (
    input  req_valid, req_addr, req_len, pl_data, pl_valid, busy, err,
    output req_ready, pl_ready, pkt_valid, tx_data, done, pkt_err, bad_req
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers a payload, then sends header, payload and
// parity bytes to a router, honouring its busy stall, and watches the
// router's error flag for a fixed window after each packet.
module router_pkt_tx (
  input  logic            clock,
  input  logic            resetn,
  router_pkt_tx_if.slave  bus
);
  localparam int unsigned ADDR_W     = 2;
  localparam int unsigned LEN_W      = 6;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned DEPTH      = 64;
  localparam int unsigned CHK_W      = 2;
  localparam int unsigned CHK_CYCLES = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    HEADER  = 3'd2,
    PAYLOAD = 3'd3,
    PARITY  = 3'd4,
    CHECK   = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  wr_ptr;
  logic [LEN_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] parity;
  logic [CHK_W-1:0]  chk_cnt;
  logic              err_seen;

  logic              req_ready_q;
  logic              pl_ready_q;
  logic              pkt_valid_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              done_q;
  logic              pkt_err_q;
  logic              bad_req_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              req_fire;
  logic              pl_fire;
  logic              req_bad;
  logic              last_wr;
  logic              last_rd;
  logic              chk_last;
  logic [LEN_W-1:0]  rd_next;

  assign bus.req_ready = req_ready_q;
  assign bus.pl_ready  = pl_ready_q;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.done      = done_q;
  assign bus.pkt_err   = pkt_err_q;
  assign bus.bad_req   = bad_req_q;

  // Handshake decode and pointer end-of-packet detection.
  assign req_fire = bus.req_valid && req_ready_q;
  assign pl_fire  = bus.pl_valid && pl_ready_q;
  assign req_bad  = (bus.req_addr == ADDR_W'(3)) || (bus.req_len == '0);
  assign last_wr  = (wr_ptr == len_q - LEN_W'(1));
  assign last_rd  = (rd_ptr == len_q - LEN_W'(1));
  assign chk_last = (chk_cnt == CHK_W'(CHK_CYCLES - 1));
  assign rd_next  = rd_ptr + LEN_W'(1);

  // Payload buffer; contents need no reset since only written bytes are read.
  always_ff @(posedge clock) begin
    if (pl_fire) begin
      mem[wr_ptr] <= bus.pl_data;
    end
  end

  // Packet sequencer with registered handshake and router outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      parity      <= '0;
      chk_cnt     <= '0;
      err_seen    <= 1'b0;
      req_ready_q <= 1'b1;
      pl_ready_q  <= 1'b0;
      pkt_valid_q <= 1'b0;
      tx_data_q   <= '0;
      done_q      <= 1'b0;
      pkt_err_q   <= 1'b0;
      bad_req_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      bad_req_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_fire) begin
            if (req_bad) begin
              bad_req_q <= 1'b1;
            end else begin
              addr_q      <= bus.req_addr;
              len_q       <= bus.req_len;
              wr_ptr      <= '0;
              parity      <= {bus.req_len, bus.req_addr};
              req_ready_q <= 1'b0;
              pl_ready_q  <= 1'b1;
              state       <= LOAD;
            end
          end
        end
        LOAD: begin
          if (pl_fire) begin
            wr_ptr <= wr_ptr + LEN_W'(1);
            parity <= parity ^ bus.pl_data;
            if (last_wr) begin
              pl_ready_q  <= 1'b0;
              pkt_valid_q <= 1'b1;
              tx_data_q   <= {len_q, addr_q};
              state       <= HEADER;
            end
          end
        end
        HEADER: begin
          if (!bus.busy) begin
            rd_ptr    <= '0;
            tx_data_q <= mem[LEN_W'(0)];
            state     <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (!bus.busy) begin
            if (last_rd) begin
              pkt_valid_q <= 1'b0;
              tx_data_q   <= parity;
              state       <= PARITY;
            end else begin
              rd_ptr    <= rd_next;
              tx_data_q <= mem[rd_next];
            end
          end
        end
        PARITY: begin
          if (!bus.busy) begin
            tx_data_q <= '0;
            chk_cnt   <= '0;
            err_seen  <= 1'b0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          chk_cnt  <= chk_cnt + CHK_W'(1);
          err_seen <= err_seen | bus.err;
          if (chk_last) begin
            done_q      <= 1'b1;
            pkt_err_q   <= err_seen | bus.err;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          pl_ready_q  <= 1'b0;
          pkt_valid_q <= 1'b0;
          tx_data_q   <= '0;
          req_ready_q <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule
